// File: rtl/out_drain_pkg.sv
// out_drain_pkg: shared definitions for the output-drain block.
//   - state_t: drain controller state (IDLE, DRAIN, DONE)
//   - DEF_* : default width/size constants used as parameter defaults
package out_drain_pkg;

    localparam int DEF_ACC_BWIDTH     = 32;
    localparam int DEF_NUM_ROWS       = 32;
    localparam int DEF_NUM_ROWS_LOG2  = 5;
    localparam int DEF_NUM_COLS       = 32;
    localparam int DEF_NUM_COLS_LOG2  = 5;
    localparam int DEF_SRAM_AWIDTH    = 10;
    localparam int DEF_BUF_DEPTH_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/out_drain_if.sv
// out_drain_if: row input stream plus output SRAM write port.
//   IN_VALID_in / IN_READY_out / IN_DATA_in : one PE-array row per handshake
//   OUT_SRAM_ADDR_out / WEn (active-low) / BE (bit mask) / D : SRAM write port
// Modports: slave = drain block side, master = producer / SRAM model side.
interface out_drain_if
    import out_drain_pkg::*;
#(
    parameter int ACC_BWIDTH = DEF_ACC_BWIDTH,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    parameter int AWIDTH     = DEF_SRAM_AWIDTH
);
    localparam int ROW_W = NUM_COLS * ACC_BWIDTH;

    logic              IN_VALID_in;
    logic              IN_READY_out;
    logic [ROW_W-1:0]  IN_DATA_in;
    logic [AWIDTH-1:0] OUT_SRAM_ADDR_out;
    logic              OUT_SRAM_WEn_out;
    logic [ROW_W-1:0]  OUT_SRAM_BE_out;
    logic [ROW_W-1:0]  OUT_SRAM_D_out;

    modport slave (
        input  IN_VALID_in, IN_DATA_in,
        output IN_READY_out, OUT_SRAM_ADDR_out, OUT_SRAM_WEn_out,
               OUT_SRAM_BE_out, OUT_SRAM_D_out
    );

    modport master (
        output IN_VALID_in, IN_DATA_in,
        input  IN_READY_out, OUT_SRAM_ADDR_out, OUT_SRAM_WEn_out,
               OUT_SRAM_BE_out, OUT_SRAM_D_out
    );
endinterface

// File: rtl/out_drain_fifo.sv
// out_drain_fifo: small show-ahead FIFO used as the row buffer.
//   CLK, RST       : clock, asynchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   pop_data       : head entry, valid whenever empty=0 (combinational read so
//                    a row can be popped the cycle after it was pushed)
//   empty, count   : occupancy status
module out_drain_fifo #(
    parameter int BWIDTH     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                push,
    input  logic [BWIDTH-1:0]   push_data,
    input  logic                pop,
    output logic [BWIDTH-1:0]   pop_data,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [BWIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != CW'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;
endmodule

// File: rtl/out_drain.sv
// out_drain: drains PE-array result rows into the output SRAM.
//   CLK, RST      : clock, asynchronous active-high reset
//   START         : tile start (only honoured in IDLE)
//   STALL         : global stall, freezes the drain and blocks writes
//   BASE_ADDR_in, ROWS_in, COLS_in : tile geometry, latched on START
//   bus (slave)   : row input handshake and SRAM write port
//   BUSY_out      : high in DRAIN and DONE
//   DONE_out      : one-cycle pulse when the last row has been written
// Optional feature: define OUT_DRAIN_RELU_EN to clamp negative elements to 0
// as rows leave the buffer (no extra latency).
module out_drain
    import out_drain_pkg::*;
#(
    parameter int ACC_BWIDTH            = DEF_ACC_BWIDTH,
    parameter int PE_ARRAY_NUM_ROWS      = DEF_NUM_ROWS,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = DEF_NUM_ROWS_LOG2,
    parameter int PE_ARRAY_NUM_COLS      = DEF_NUM_COLS,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = DEF_NUM_COLS_LOG2,
    parameter int OUT_SRAM_AWIDTH        = DEF_SRAM_AWIDTH,
    parameter int BUF_DEPTH_LOG2         = DEF_BUF_DEPTH_LOG2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic                              STALL,
    input  logic [OUT_SRAM_AWIDTH-1:0]        BASE_ADDR_in,
    input  logic [PE_ARRAY_NUM_ROWS_LOG2:0]   ROWS_in,
    input  logic [PE_ARRAY_NUM_COLS_LOG2:0]   COLS_in,
    out_drain_if.slave                        bus,
    output logic                              BUSY_out,
    output logic                              DONE_out
);
    localparam int ROW_W     = PE_ARRAY_NUM_COLS * ACC_BWIDTH;
    localparam int RW        = PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam int CLW       = PE_ARRAY_NUM_COLS_LOG2 + 1;
    localparam int CNTW      = BUF_DEPTH_LOG2 + 1;
    localparam int BUF_DEPTH = 1 << BUF_DEPTH_LOG2;

    state_t                     state_q, state_d;
    logic [OUT_SRAM_AWIDTH-1:0] base_q, base_d;
    logic [RW-1:0]              rows_q, rows_d;
    logic [CLW-1:0]             cols_q, cols_d;
    logic [RW-1:0]              acc_q, acc_d;     // rows accepted
    logic [RW-1:0]              wr_q, wr_d;       // rows written
    logic                       ready_q, ready_d;
    logic                       wen_q, wen_d;
    logic [OUT_SRAM_AWIDTH-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]           dout_q, dout_d;
    logic [ROW_W-1:0]           be_q, be_d;

    logic             push, pop;
    logic [ROW_W-1:0] fifo_data, pop_row, be_mask;
    logic             fifo_empty;
    logic [CNTW-1:0]  fifo_count, cnt_next;

    out_drain_fifo #(
        .BWIDTH     (ROW_W),
        .DEPTH_LOG2 (BUF_DEPTH_LOG2)
    ) u_row_buf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (bus.IN_DATA_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PE_ARRAY_NUM_COLS; gi++) begin : g_col
            localparam logic [CLW-1:0] COL_IDX = CLW'(gi);
            assign be_mask[gi*ACC_BWIDTH +: ACC_BWIDTH] =
                (COL_IDX < cols_q) ? {ACC_BWIDTH{1'b1}} : {ACC_BWIDTH{1'b0}};
`ifdef OUT_DRAIN_RELU_EN
            assign pop_row[gi*ACC_BWIDTH +: ACC_BWIDTH] =
                fifo_data[gi*ACC_BWIDTH + ACC_BWIDTH - 1] ? {ACC_BWIDTH{1'b0}}
                                                           : fifo_data[gi*ACC_BWIDTH +: ACC_BWIDTH];
`endif
        end
    endgenerate

`ifndef OUT_DRAIN_RELU_EN
    assign pop_row = fifo_data;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        wen_d   = 1'b1;
        addr_d  = addr_q;
        dout_d  = dout_q;
        be_d    = be_q;
        pop     = 1'b0;
        // A handshake on an already-advertised ready always completes, even in
        // the first stall cycle, so an accepted row is never dropped.
        push    = bus.IN_VALID_in && ready_q;

        case (state_q)
            IDLE: begin
                if (START && !STALL) begin
                    base_d  = BASE_ADDR_in;
                    rows_d  = (ROWS_in > RW'(PE_ARRAY_NUM_ROWS)) ? RW'(PE_ARRAY_NUM_ROWS) : ROWS_in;
                    cols_d  = (COLS_in > CLW'(PE_ARRAY_NUM_COLS)) ? CLW'(PE_ARRAY_NUM_COLS) : COLS_in;
                    acc_d   = '0;
                    wr_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!STALL) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        wen_d  = 1'b0;
                        addr_d = base_q + OUT_SRAM_AWIDTH'(wr_q);
                        dout_d = pop_row;
                        be_d   = be_mask;
                        wr_d   = wr_q + RW'(1);
                    end
                    // Also covers an empty tile: 0 == 0 on the first cycle.
                    if (wr_d == rows_q) state_d = DONE;
                end
            end
            DONE: begin
                if (!STALL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) acc_d = acc_d + RW'(1);

        // Ready is registered, so it is judged on next-cycle occupancy without
        // counting on a pop that may or may not happen in that cycle.
        cnt_next = fifo_count + CNTW'(push) - CNTW'(pop);
        ready_d  = (state_d == DRAIN) && (cnt_next < CNTW'(BUF_DEPTH)) &&
                   (acc_d < rows_d) && !STALL;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            ready_q <= 1'b0;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            be_q    <= be_d;
        end
    end

    assign bus.IN_READY_out      = ready_q;
    assign bus.OUT_SRAM_WEn_out  = wen_q;
    assign bus.OUT_SRAM_ADDR_out = addr_q;
    assign bus.OUT_SRAM_D_out    = dout_q;
    assign bus.OUT_SRAM_BE_out   = be_q;
    assign BUSY_out              = (state_q != IDLE);
    assign DONE_out              = (state_q == DONE);
endmodule

// File: tb/tb_out_drain.sv
// tb_out_drain: directed self-checking bench for out_drain.
module tb_out_drain;
    localparam int AW    = 10;
    localparam int NC    = 32;
    localparam int ACC   = 32;
    localparam int ROW_W = NC * ACC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic [AW-1:0] base_addr;
    logic [5:0]    rows_in;
    logic [5:0]    cols_in;
    logic          busy;
    logic          done;

    out_drain_if #(.ACC_BWIDTH(ACC), .NUM_COLS(NC), .AWIDTH(AW)) bus ();

    out_drain dut (
        .CLK          (clk),
        .RST          (rst),
        .START        (start),
        .STALL        (stall),
        .BASE_ADDR_in (base_addr),
        .ROWS_in      (rows_in),
        .COLS_in      (cols_in),
        .bus          (bus),
        .BUSY_out     (busy),
        .DONE_out     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]    wq_addr [$];
    logic [ROW_W-1:0] wq_data [$];
    logic [ROW_W-1:0] wq_be   [$];
    int               done_cnt = 0;

    // Write-port monitor: one line per SRAM write.
    always @(negedge clk) begin
        if (bus.OUT_SRAM_WEn_out === 1'b0) begin
            wq_addr.push_back(bus.OUT_SRAM_ADDR_out);
            wq_data.push_back(bus.OUT_SRAM_D_out);
            wq_be.push_back(bus.OUT_SRAM_BE_out);
            $display("write addr=%03h d[63:0]=%h", bus.OUT_SRAM_ADDR_out, bus.OUT_SRAM_D_out[63:0]);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        int idx = 0;
        for (int c = NC - 1; c >= 0; c--)
            if (obs[c*ACC +: ACC] !== exp[c*ACC +: ACC]) idx = c;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s elem %0d observed=%h expected=%h", tag, idx,
                   obs[idx*ACC +: ACC], exp[idx*ACC +: ACC]);
        end
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input int seed, input int k);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < NC; c++) begin
            if (seed == 255)
                r[c*ACC +: ACC] = (c == 0) ? 32'hFFFF_FFFF : (c == 1) ? 32'h0000_0007 : 32'(c);
            else
                r[c*ACC +: ACC] = {8'(seed), 8'(k), 16'(c)};
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int seed, input int k);
        logic [ROW_W-1:0] r;
        r = mk_row(seed, k);
`ifdef OUT_DRAIN_RELU_EN
        for (int c = 0; c < NC; c++)
            if (r[c*ACC + ACC - 1]) r[c*ACC +: ACC] = '0;
`endif
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] exp_be(input int cols);
        logic [ROW_W-1:0] m = '0;
        for (int c = 0; c < NC; c++)
            if (c < cols) m[c*ACC +: ACC] = '1;
        return m;
    endfunction

    // Start a tile and feed rows with IN_VALID held; optional stall window
    // (in feed cycles) and optional early exit after a number of writes.
    task automatic run_tile(input logic [AW-1:0] base, input int rows, input int cols,
                            input int seed, input int stall_start, input int stall_len,
                            input int abort_writes);
        int  k = 0;
        bit  finished = 0;
        bit  aborted = 0;
        bit  hs;
        bit  in_st;
        wq_addr.delete(); wq_data.delete(); wq_be.delete();
        done_cnt  = 0;
        base_addr = base;
        rows_in   = 6'(rows);
        cols_in   = 6'(cols);
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished && !aborted; cyc++) begin
            if (abort_writes > 0 && wq_addr.size() >= abort_writes) begin
                aborted = 1;
            end else begin
                in_st           = (cyc >= stall_start) && (cyc < stall_start + stall_len);
                stall           = in_st;
                bus.IN_VALID_in = (k < rows);
                bus.IN_DATA_in  = mk_row(seed, k);
                hs              = bus.IN_VALID_in && bus.IN_READY_out;
                step();
                if (hs) k++;
                if (in_st) begin
                    chk($sformatf("stall_wen_c%0d", cyc), 64'(bus.OUT_SRAM_WEn_out), 64'd1);
                    chk($sformatf("stall_ready_c%0d", cyc), 64'(bus.IN_READY_out), 64'd0);
                end
                if (done === 1'b1) finished = 1;
            end
        end
        stall           = 1'b0;
        bus.IN_VALID_in = 1'b0;
        $display("tile base=%03h rows=%0d cols=%0d accepted=%0d writes=%0d", base, rows, cols, k, wq_addr.size());
        chk("tile_end_reached", 64'(finished || aborted), 64'd1);
    endtask

    task automatic check_writes(input logic [AW-1:0] base, input int rows, input int cols_eff, input int seed);
        logic [AW-1:0] a;
        chk("write_count", 64'(wq_addr.size()), 64'(rows));
        for (int i = 0; i < wq_addr.size() && i < rows; i++) begin
            a = base + AW'(i);
            chk($sformatf("addr_%0d", i), 64'(wq_addr[i]), 64'(a));
            chk_row($sformatf("data_%0d", i), wq_data[i], exp_row(seed, i));
            chk_row($sformatf("be_%0d", i), wq_be[i], exp_be(cols_eff));
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ready"}, 64'(bus.IN_READY_out), 64'd0);
        chk({pfx, "_wen"},   64'(bus.OUT_SRAM_WEn_out), 64'd1);
        chk({pfx, "_addr"},  64'(bus.OUT_SRAM_ADDR_out), 64'd0);
        chk_row({pfx, "_be"}, bus.OUT_SRAM_BE_out, '0);
        chk_row({pfx, "_d"},  bus.OUT_SRAM_D_out, '0);
        chk({pfx, "_busy"},  64'(busy), 64'd0);
        chk({pfx, "_done"},  64'(done), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        base_addr = '0; rows_in = '0; cols_in = '0;
        bus.IN_VALID_in = 1'b0; bus.IN_DATA_in = '0;
        step(); step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Address wrap across the top of the SRAM, back-to-back rows.
        run_tile(10'h3FE, 4, 32, 1, 1000, 0, 0);
        step();
        chk("wrap_done_low", 64'(done), 64'd0);
        chk("wrap_busy_low", 64'(busy), 64'd0);
        chk("wrap_done_pulses", 64'(done_cnt), 64'd1);
        check_writes(10'h3FE, 4, 32, 1);

        // Partial column count: BE covers columns 0..4 only.
        run_tile(10'h020, 2, 5, 2, 1000, 0, 0);
        step();
        check_writes(10'h020, 2, 5, 2);

        // Column count above the array width clamps to all columns.
        run_tile(10'h028, 1, 40, 3, 1000, 0, 0);
        step();
        check_writes(10'h028, 1, 32, 3);

        // Stall for 6 cycles in mid-stream: no writes, ready low, order kept.
        run_tile(10'h010, 8, 32, 6, 4, 6, 0);
        step();
        chk("stall_done_pulses", 64'(done_cnt), 64'd1);
        check_writes(10'h010, 8, 32, 6);

        // Empty tile: DONE one cycle after entering DRAIN, no writes.
        wq_addr.delete(); wq_data.delete(); wq_be.delete();
        base_addr = 10'h050; rows_in = 6'd0; cols_in = 6'd32;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r0_busy_drain", 64'(busy), 64'd1);
        chk("r0_done_drain", 64'(done), 64'd0);
        step();
        chk("r0_done_pulse", 64'(done), 64'd1);
        step();
        chk("r0_done_after", 64'(done), 64'd0);
        chk("r0_busy_after", 64'(busy), 64'd0);
        chk("r0_no_writes", 64'(wq_addr.size()), 64'd0);

        // ReLU behaviour on a single row.
        run_tile(10'h030, 1, 32, 255, 1000, 0, 0);
        step();
        check_writes(10'h030, 1, 32, 255);
        if (wq_data.size() > 0) begin
`ifdef OUT_DRAIN_RELU_EN
            chk("relu_elem0", 64'(wq_data[0][31:0]), 64'h0000_0000);
`else
            chk("relu_elem0", 64'(wq_data[0][31:0]), 64'hFFFF_FFFF);
`endif
            chk("relu_elem1", 64'(wq_data[0][63:32]), 64'h0000_0007);
        end

        // Reset in the middle of an 8-row tile after two writes.
        run_tile(10'h200, 8, 32, 4, 1000, 0, 2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        n = wq_addr.size();
        chk("midrst_writes", 64'(n), 64'd2);
        step(); step();
        rst = 1'b0;
        bus.IN_VALID_in = 1'b1;
        bus.IN_DATA_in  = mk_row(9, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle_ready_%0d", i), 64'(bus.IN_READY_out), 64'd0);
        end
        bus.IN_VALID_in = 1'b0;
        step();
        chk("midrst_no_new_writes", 64'(wq_addr.size()), 64'(n));

        run_tile(10'h200, 8, 32, 5, 1000, 0, 0);
        step();
        chk("restart_done_pulses", 64'(done_cnt), 64'd1);
        check_writes(10'h200, 8, 32, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_drain.md
OUT_DRAIN -- requirements
Module: out_drain

Interface
REQ-001 SHALL have parameter ACC_BWIDTH, default 32, bit width of one accumulated INT32 result.
REQ-002 SHALL have parameter PE_ARRAY_NUM_ROWS / PE_ARRAY_NUM_ROWS_LOG2, defaults 32 / 5, rows per tile.
REQ-003 SHALL have parameter PE_ARRAY_NUM_COLS / PE_ARRAY_NUM_COLS_LOG2, defaults 32 / 5, results per row.
REQ-004 SHALL have parameter OUT_SRAM_AWIDTH, default 10, output SRAM address width.
REQ-005 SHALL have parameter BUF_DEPTH_LOG2, default 2, row buffer depth 2^BUF_DEPTH_LOG2.
REQ-006 SHALL have port CLK, input, 1, the single clock; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports: START in 1 (tile start); STALL in 1 (global stall); BASE_ADDR_in in OUT_SRAM_AWIDTH; ROWS_in in PE_ARRAY_NUM_ROWS_LOG2+1 (rows to drain); COLS_in in PE_ARRAY_NUM_COLS_LOG2+1 (valid columns).
REQ-009 SHALL have ports: IN_VALID_in in 1; IN_READY_out out 1; IN_DATA_in in PE_ARRAY_NUM_COLS*ACC_BWIDTH (one PE-array output row, column 0 at LSBs).
REQ-010 SHALL have ports: OUT_SRAM_ADDR_out out OUT_SRAM_AWIDTH; OUT_SRAM_WEn_out out 1 (active-low); OUT_SRAM_BE_out out PE_ARRAY_NUM_COLS*ACC_BWIDTH (bit mask); OUT_SRAM_D_out out PE_ARRAY_NUM_COLS*ACC_BWIDTH; BUSY_out out 1; DONE_out out 1.

Function
REQ-011 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE: START=1 latches BASE_ADDR_in, ROWS_in, min(COLS_in, PE_ARRAY_NUM_COLS), clears counters, moves to DRAIN; START outside IDLE is ignored.
REQ-013 IN_READY_out registered, =1 only in DRAIN when buffer not full, accepted-count < rows, STALL=0; no same-cycle pop bypass.
REQ-014 Row accepted on IN_VALID_in & IN_READY_out; pushed into row buffer in order.
REQ-015 In DRAIN with buffer non-empty and STALL=0: pop one row/cycle, next cycle drive WEn=0, ADDR=base+written-count, D=row, BE ones on columns 0..cols-1, zero above.
REQ-016 Minimum latency: row accepted at edge t appears on SRAM write port in cycle after edge t+1.
REQ-017 Address arithmetic SHALL wrap modulo 2^OUT_SRAM_AWIDTH.
REQ-018 STALL=1 SHALL drive WEn=1, hold all counters, buffer and state.
REQ-019 When written-count reaches rows: move to DONE; DONE_out=1 for exactly one cycle; then IDLE.
REQ-020 ROWS_in=0 SHALL go DRAIN -> DONE in one cycle with no writes.
REQ-021 BUSY_out=1 in DRAIN and DONE, else 0.
REQ-022 Outside a write cycle WEn=1; ADDR, D, BE hold last value.

Reset
REQ-023 RST=1 SHALL asynchronously force IDLE, empty buffer, clear counters; outputs: IN_READY 0, WEn 1, ADDR 0, BE 0, D 0, BUSY 0, DONE 0.
REQ-024 Reset mid-DRAIN discards buffered rows; no further writes until next START.

Configuration
REQ-025 Macro OUT_DRAIN_RELU_EN defined: each ACC_BWIDTH element negative (MSB=1) is written as 0, applied at pop, zero added latency.
REQ-026 Macro undefined: data written unmodified; no ReLU logic present.

Structure
REQ-027 Shared package SHALL hold FSM state typedef (IDLE, DRAIN, DONE) and default width constants.
REQ-028 Row buffer SHALL be the existing FIFO sub-module, BWIDTH=PE_ARRAY_NUM_COLS*ACC_BWIDTH, DEPTH=2^BUF_DEPTH_LOG2.

Verification
REQ-029 START base=0x3FE, rows=4, cols=32, rows fed back-to-back -> writes at 0x3FE,0x3FF,0x000,0x001, DONE pulse once.
REQ-030 cols=5 -> BE = 0 above bit 159, ones at bits 159..0 on every write.
REQ-031 IN_VALID held, writes blocked by STALL for 6 cycles -> IN_READY drops after 4 rows, no write, no data loss, order preserved.
REQ-032 ROWS_in=0 -> DONE_out one cycle after DRAIN entry, WEn never 0.
REQ-033 RST after 2 of 8 rows -> all outputs at reset values same cycle; new START 8 rows writes from base cleanly.
REQ-034 With OUT_DRAIN_RELU_EN, row elements 0xFFFFFFFF,0x00000007 -> written as 0x00000000,0x00000007; without it unchanged.
